// File: rtl/unflatten_stream_if.sv
// Stream-in / map-out bundle for unflatten_stream.
// The slave side is the unflatten block; the master side is whoever feeds
// words and consumes the rebuilt map.
interface unflatten_stream_if #(
    parameter int BITS = 8,
    parameter int DIM  = 32,
    parameter int WORD = 32
);
    localparam int MW = $clog2(DIM) + 1;

    logic                              start;
    logic [MW-1:0]                     m;
    logic [MW-1:0]                     n;
    logic                              in_valid;
    logic                              in_ready;
    logic [WORD-1:0]                   in_data;
    logic [DIM-1:0][DIM-1:0][BITS-1:0] OUT;
    logic                              busy;
    logic                              done;

    modport master (
        output start, m, n, in_valid, in_data,
        input  in_ready, OUT, busy, done
    );

    modport slave (
        input  start, m, n, in_valid, in_data,
        output in_ready, OUT, busy, done
    );
endinterface

// File: rtl/unflatten_stream.sv
// unflatten_stream: rebuilds a row-major m x n region of pixels, packed
// PPW per word, into a DIM x DIM register map. Locations outside the region
// stay zero; done pulses for one cycle once the last pixel has landed.
module unflatten_stream #(
    parameter int BITS = 8,
    parameter int DIM  = 32,
    parameter int WORD = 32
) (
    input logic            clk,
    input logic            rst_n,
    unflatten_stream_if.slave s
);
    localparam int PPW = WORD / BITS;
    localparam int MW  = $clog2(DIM) + 1;
    localparam int AW  = $clog2(DIM);
    localparam int CW  = $clog2(DIM * DIM) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                        state_q, state_d;
    logic [MW-1:0]                     n_q, n_d;
    logic [MW-1:0]                     row_q, row_d;
    logic [MW-1:0]                     col_q, col_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic [DIM-1:0][DIM-1:0][BITS-1:0] out_q, out_d;

    logic [MW-1:0] m_clamp;
    logic [MW-1:0] n_clamp;
    logic [CW-1:0] area;

    // Requested dimensions larger than the map are clamped to DIM.
    assign m_clamp = (s.m > MW'(DIM)) ? MW'(DIM) : s.m;
    assign n_clamp = (s.n > MW'(DIM)) ? MW'(DIM) : s.n;
    assign area    = CW'(m_clamp) * CW'(n_clamp);

    // Handshake/status are pure state decodes, no input-to-output paths.
    assign s.in_ready = (state_q == S_LOAD);
    assign s.busy     = (state_q != S_IDLE);
    assign s.done     = (state_q == S_DONE);
    assign s.OUT      = out_q;

    // Next-state: start capture, per-lane scatter with row wrap, completion.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (s.start) begin
                    n_d     = n_clamp;
                    row_d   = '0;
                    col_d   = '0;
                    cnt_d   = area;
                    out_d   = '0;
                    state_d = (area == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (s.in_valid) begin
                    // Lanes past the final pixel leave map and pointer untouched.
                    for (int i = 0; i < PPW; i++) begin
                        if (cnt_d != '0) begin
                            out_d[row_d[AW-1:0]][col_d[AW-1:0]] = s.in_data[BITS*i +: BITS];
                            cnt_d = cnt_d - CW'(1);
                            if (col_d == n_q - MW'(1)) begin
                                col_d = '0;
                                row_d = row_d + MW'(1);
                            end else begin
                                col_d = col_d + MW'(1);
                            end
                        end
                    end
                    if (cnt_d == '0) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pointer, counter and map registers; reset wipes the map too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end
endmodule

// File: tb/tb_unflatten_stream.sv
// Directed bench for unflatten_stream (BITS=8, DIM=32, WORD=32, PPW=4).
module tb_unflatten_stream;
    localparam int BITS = 8;
    localparam int DIM  = 32;
    localparam int WORD = 32;
    localparam int MW   = $clog2(DIM) + 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   done_cnt;
    int   d0;

    logic [7:0] exp_m [DIM][DIM];

    unflatten_stream_if #(.BITS(BITS), .DIM(DIM), .WORD(WORD)) s ();

    unflatten_stream #(.BITS(BITS), .DIM(DIM), .WORD(WORD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses as seen at each rising edge.
    initial done_cnt = 0;
    always @(posedge clk) begin
        if (s.done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_exp();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                exp_m[r][c] = 8'h00;
    endtask

    task automatic check_map(input string tag);
        int bad;
        bad = 0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                if (s.OUT[r][c] !== exp_m[r][c]) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int mm, input int nn);
        s.start = 1'b1;
        s.m     = MW'(mm);
        s.n     = MW'(nn);
        tick();
        s.start = 1'b0;
    endtask

    // Present one word and hold it until it is accepted (bounded wait).
    task automatic send(input logic [31:0] d);
        int k;
        s.in_valid = 1'b1;
        s.in_data  = d;
        k = 0;
        while (!s.in_ready && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) check("rdy_timeout", 32'(s.in_ready), 32'd1);
        tick();
        s.in_valid = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        s.start    = 1'b0;
        s.m        = '0;
        s.n        = '0;
        s.in_valid = 1'b0;
        s.in_data  = '0;
        rst_n      = 1'b0;
        clear_exp();

        // Reset state
        tick();
        tick();
        check("rst_ready", 32'(s.in_ready), 32'd0);
        check("rst_busy",  32'(s.busy),     32'd0);
        check("rst_done",  32'(s.done),     32'd0);
        check_map("rst_map");
        rst_n = 1'b1;
        tick();

        // 3x3 map, trailing lanes ignored
        d0 = done_cnt;
        do_start(3, 3);
        check("t1_ready", 32'(s.in_ready), 32'd1);
        check("t1_busy",  32'(s.busy),     32'd1);
        send(32'h04030201);
        send(32'h08070605);
        check("t1_nodone", 32'(s.done), 32'd0);
        send(32'hAABBCC09);
        check("t1_done", 32'(s.done), 32'd1);
        exp_m[0][0] = 8'd1; exp_m[0][1] = 8'd2; exp_m[0][2] = 8'd3;
        exp_m[1][0] = 8'd4; exp_m[1][1] = 8'd5; exp_m[1][2] = 8'd6;
        exp_m[2][0] = 8'd7; exp_m[2][1] = 8'd8; exp_m[2][2] = 8'd9;
        check("t1_p00", 32'(s.OUT[0][0]), 32'h01);
        check("t1_p22", 32'(s.OUT[2][2]), 32'h09);
        check("t1_p03", 32'(s.OUT[0][3]), 32'h00);
        check("t1_p30", 32'(s.OUT[3][0]), 32'h00);
        check_map("t1_map");
        tick();
        check("t1_done_off", 32'(s.done),     32'd0);
        check("t1_idle",     32'(s.busy),     32'd0);
        check("t1_rdy_off",  32'(s.in_ready), 32'd0);
        check("t1_ndone", 32'(done_cnt - d0), 32'd1);

        // Word presented in IDLE is not consumed
        s.in_valid = 1'b1;
        s.in_data  = 32'hDEADBEEF;
        tick();
        tick();
        s.in_valid = 1'b0;
        check_map("idle_word_map");
        check("idle_word_busy", 32'(s.busy), 32'd0);

        // Multi-row wrap, n=1
        clear_exp();
        do_start(5, 1);
        send(32'h44332211);
        send(32'h00000055);
        check("t2_done", 32'(s.done), 32'd1);
        exp_m[0][0] = 8'h11; exp_m[1][0] = 8'h22; exp_m[2][0] = 8'h33;
        exp_m[3][0] = 8'h44; exp_m[4][0] = 8'h55;
        check("t2_p40", 32'(s.OUT[4][0]), 32'h55);
        check_map("t2_map");
        tick();

        // Empty region: done straight after start, map cleared
        clear_exp();
        d0 = done_cnt;
        do_start(0, 7);
        check("t3_done",  32'(s.done),     32'd1);
        check("t3_ready", 32'(s.in_ready), 32'd0);
        check_map("t3_map");
        tick();
        check("t3_idle", 32'(s.busy), 32'd0);
        check("t3_ndone", 32'(done_cnt - d0), 32'd1);

        // Clamped region: m=40 -> 32 rows, 8 words
        clear_exp();
        do_start(40, 1);
        for (int w = 0; w < 8; w++) begin
            if (w == 7) check("t3b_nodone", 32'(s.done), 32'd0);
            send({8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)});
        end
        check("t3b_done", 32'(s.done), 32'd1);
        for (int r = 0; r < DIM; r++) exp_m[r][0] = 8'(r + 1);
        check("t3b_p310", 32'(s.OUT[31][0]), 32'd32);
        check_map("t3b_map");
        tick();

        // Backpressure with an ignored mid-LOAD start
        clear_exp();
        d0 = done_cnt;
        do_start(2, 2);
        s.in_data = 32'h0D0C0B0A;
        s.in_valid = 1'b0;
        s.start = 1'b1;
        s.m = MW'(1);
        s.n = MW'(1);
        tick();
        check("t4_stall_rdy", 32'(s.in_ready), 32'd1);
        tick();
        s.start = 1'b0;
        check("t4_stall_done", 32'(s.done), 32'd0);
        check_map("t4_stall_map");
        send(32'h0D0C0B0A);
        check("t4_done", 32'(s.done), 32'd1);
        exp_m[0][0] = 8'h0A; exp_m[0][1] = 8'h0B;
        exp_m[1][0] = 8'h0C; exp_m[1][1] = 8'h0D;
        check_map("t4_map");
        tick();
        tick();
        tick();
        check("t4_ndone", 32'(done_cnt - d0), 32'd1);
        check("t4_idle",  32'(s.busy),        32'd0);

        // Asynchronous reset mid-load, then a clean 2x2 map
        d0 = done_cnt;
        do_start(4, 4);
        send(32'h14131211);
        send(32'h18171615);
        #2;
        rst_n = 1'b0;
        #1;
        clear_exp();
        check_map("t5_rst_map");
        check("t5_rst_busy",  32'(s.busy),     32'd0);
        check("t5_rst_ready", 32'(s.in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_ndone", 32'(done_cnt - d0), 32'd0);
        do_start(2, 2);
        send(32'h24232221);
        check("t5_done", 32'(s.done), 32'd1);
        exp_m[0][0] = 8'h21; exp_m[0][1] = 8'h22;
        exp_m[1][0] = 8'h23; exp_m[1][1] = 8'h24;
        check_map("t5_map");
        tick();

        // Back-to-back maps: start in the IDLE cycle right after done
        clear_exp();
        do_start(2, 3);
        send(32'h04030201);
        send(32'h00000605);
        check("t6_done1", 32'(s.done), 32'd1);
        exp_m[0][0] = 8'd1; exp_m[0][1] = 8'd2; exp_m[0][2] = 8'd3;
        exp_m[1][0] = 8'd4; exp_m[1][1] = 8'd5; exp_m[1][2] = 8'd6;
        check_map("t6_map1");
        tick();
        check("t6_idle", 32'(s.busy), 32'd0);
        do_start(1, 2);
        check("t6_restart", 32'(s.in_ready), 32'd1);
        clear_exp();
        check_map("t6_cleared");
        send(32'h0000BBAA);
        check("t6_done2", 32'(s.done), 32'd1);
        exp_m[0][0] = 8'hAA; exp_m[0][1] = 8'hBB;
        check_map("t6_map2");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/unflatten_stream.md
# unflatten_stream

Rebuilds a 2-D feature map from a packed stream of 32-bit words. It is the receive-side counterpart of the accelerator's flatten step: pixels of an m×n region arrive row-major, several per word, and are written into a DIM×DIM register map. Every location outside the m×n region reads zero. The block sits between the memory/bus read path and the convolution engine's feature-map input, and it signals `done` when the map is complete and stable.

## Interface
- `BITS`, 8, bit width of one pixel
- `DIM`, 32, maximum feature-map dimension
- `WORD`, 32, stream word width; `PPW = WORD/BITS` pixels per word (must divide evenly)
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a new map; sampled only in IDLE
- `m`  in  $clog2(DIM)+1  row count of the region; sampled on accepted `start`
- `n`  in  $clog2(DIM)+1  column count of the region; sampled on accepted `start`
- `in_valid`  in  1  `in_data` holds a valid word
- `in_ready`  out  1  block accepts a word this cycle
- `in_data`  in  WORD  packed pixels; lane i is `[BITS*i +: BITS]`, lane 0 is first in order
- `OUT`  out  [BITS-1:0] × [DIM-1:0][DIM-1:0]  reconstructed map, indexed [row][col]
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  single-cycle pulse when the map is complete

## Operation
- States are IDLE, LOAD and DONE.
- **IDLE:**
  - On `start`=1, latch `m` and `n`. Any value above DIM is clamped to DIM.
  - Clear all of `OUT` to 0 and reset the write pointer to (row=0, col=0).
  - Load the pixel counter with m·n.
  - If m·n = 0, go to DONE. Otherwise go to LOAD.
- **LOAD:**
  - `in_ready`=1. A word is accepted when `in_valid && in_ready`.
  - On acceptance, lanes 0..PPW-1 are written in order. Each lane's target is the previous lane's target advanced by one position.
  - Advancing wraps col from n-1 to 0 and increments row. Any number of row wraps per word is legal; n=1 gives PPW rows per word.
  - Lanes that fall after the final pixel (counter exhausted) are ignored. They write nothing and do not move the pointer.
  - When the last pixel is written, go to DONE.
  - Words needed per map: ceil(m·n / PPW).
- **DONE:** `done`=1 for exactly one cycle, then return to IDLE.
- **Start and busy:**
  - `start` is ignored while `busy`=1.
  - `start` in the IDLE cycle that follows DONE is accepted normally.
- **OUT stability:**
  - `OUT` holds its value from DONE until the next accepted `start`.
  - While a map is loading, locations not yet written read 0.
- **Write bound:** no write ever lands at row ≥ m or col ≥ n.

## Timing
- **Reset:** asynchronous assertion of `rst_n`=0 immediately forces:
  - state to IDLE;
  - `OUT` to all zeros;
  - `in_ready`=0, `busy`=0, `done`=0;
  - pointer and counter to 0.
- **Reset mid-LOAD:** the partial map is discarded. No `done` is produced.
- **Start acceptance:** `start` accepted at edge t:
  - LOAD is entered at t+1; `in_ready`=1 in that cycle.
  - For m·n=0, DONE is entered at t+1 and `done`=1 in that cycle.
- **Final word:** if the last word is accepted at edge t:
  - `OUT` shows all pixels and `done`=1 in cycle t+1;
  - `busy`=0 and `in_ready`=0 from t+2.
- **Throughput and stalls:**
  - Throughput is one word per cycle.
  - `in_valid`=0 stalls with no state change.
  - A word presented while `in_ready`=0 is not consumed and has no effect.
- **Outputs:** `in_ready`, `busy` and `done` are decoded from state registers only; there is no combinational path from inputs.
- **Minimum cycle count:** start to `done` is ceil(m·n/PPW)+1 cycles with no stalls.

## Test plan
- **3×3 map, PPW=4:**
  - Stimulus: start m=3, n=3; words 0x04030201, 0x08070605, 0xAABBCC09.
  - Required: OUT[0][0..2]=1,2,3; OUT[1][0..2]=4,5,6; OUT[2][0..2]=7,8,9.
  - Lanes carrying 0xCC/0xBB/0xAA are ignored. OUT[0][3]=0 and OUT[3][0]=0.
  - `done` one cycle after the third accept.
- **Multi-row wrap:**
  - Stimulus: start m=5, n=1; words 0x44332211, 0x00000055.
  - Required: OUT[0..4][0]=0x11,0x22,0x33,0x44,0x55; every other location 0.
- **Empty and clamped region:**
  - m=0, n=7: `done` in the cycle after start, `in_ready` never high, OUT all 0.
  - m=40, n=1: exactly 8 words are accepted and all 32 rows of column 0 are filled.
- **Backpressure and busy start:**
  - Stimulus: 2×2 map; `in_valid` toggles 1,0,0,1; `start` pulsed mid-LOAD with m=1.
  - Required: only 1 word is needed; the mid-LOAD start is ignored.
  - Required: the map matches the stream and `done` fires exactly once.
- **Reset mid-load then reuse:**
  - Stimulus: start 4×4; accept 2 of 4 words; pulse `rst_n` low asynchronously.
  - Required: OUT is immediately all 0 and `busy`=0.
  - Required: a following 2×2 load completes correctly with no leftover pixels.
- **Back-to-back maps:**
  - Stimulus: start a 2×3 map; assert `start` again in the IDLE cycle right after `done`.
  - Required: the new start is accepted and OUT is cleared.
  - Required: the second map's pixels are not mixed with the first.
